// File: rtl/sdram_stream_pkg.sv
// Shared encodings and defaults for the SDRAM stream generator/checker pair.
package sdram_stream_pkg;

  typedef enum logic [1:0] {
    MODE_CNT  = 2'd0,
    MODE_LFSR = 2'd1,
    MODE_WALK = 2'd2,
    MODE_CHK  = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [63:0] DEF_LFSR_POLY = 64'h0000_0000_8020_0003;
  localparam logic [63:0] DEF_LFSR_SEED = 64'h0000_0000_0000_0001;

  // 0x55..55 fill; callers keep the low DATA_W bits.
  function automatic logic [63:0] chk_fill();
    logic [63:0] r;
    r = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      r[i] = ((i % 2) == 0);
    end
    return r;
  endfunction

endpackage

// File: rtl/pattern_core.sv
// Pattern register: loads the start word for a mode and steps to the next
// word on advance. Shared with the stream checker for expected-data generation.
module pattern_core
  import sdram_stream_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter logic [63:0] LFSR_POLY = DEF_LFSR_POLY,
  parameter logic [63:0] LFSR_SEED = DEF_LFSR_SEED
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              load_i,
  input  logic              advance_i,
  input  mode_t             mode_i,
  output logic [DATA_W-1:0] word_o
);

  localparam logic [DATA_W-1:0] POLY  = LFSR_POLY[DATA_W-1:0];
  localparam logic [DATA_W-1:0] SEED  = LFSR_SEED[DATA_W-1:0];
  localparam logic [63:0]       CHK64 = chk_fill();
  localparam logic [DATA_W-1:0] CHK   = CHK64[DATA_W-1:0];

  logic [DATA_W-1:0] pat_q;
  logic [DATA_W-1:0] pat_d;

  // Next pattern word: load takes priority over advance.
  always_comb begin
    pat_d = pat_q;
    if (load_i) begin
      unique case (mode_i)
        MODE_CNT:  pat_d = '0;
        MODE_LFSR: pat_d = SEED;
        MODE_WALK: pat_d = {{(DATA_W-1){1'b0}}, 1'b1};
        MODE_CHK:  pat_d = CHK;
        default:   pat_d = '0;
      endcase
    end else if (advance_i) begin
      unique case (mode_i)
        MODE_CNT:  pat_d = pat_q + 1'b1;
        MODE_LFSR: pat_d = (pat_q >> 1) ^ (pat_q[0] ? POLY : '0);
        MODE_WALK: pat_d = {pat_q[DATA_W-2:0], pat_q[DATA_W-1]};
        MODE_CHK:  pat_d = ~pat_q;
        default:   pat_d = pat_q;
      endcase
    end
  end

  // Pattern register; resets to the counter start value.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) pat_q <= '0;
    else        pat_q <= pat_d;
  end

  assign word_o = pat_q;

endmodule

// File: rtl/stream_pattern_gen.sv
// Rate-timed test-stream source: emits pattern words over valid/ready,
// supports finite bursts, continuous runs, early stop and overrun flagging.
module stream_pattern_gen
  import sdram_stream_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned PERIOD_W  = 8,
  parameter int unsigned LEN_W     = 16,
  parameter logic [63:0] LFSR_POLY = DEF_LFSR_POLY,
  parameter logic [63:0] LFSR_SEED = DEF_LFSR_SEED
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                enable,
  input  logic                start,
  input  logic                stop,
  input  logic [1:0]          mode,
  input  logic [PERIOD_W-1:0] period,
  input  logic [LEN_W-1:0]    burst_len,
  output logic [DATA_W-1:0]   data,
  output logic                valid,
  input  logic                ready,
  output logic                busy,
  output logic                done,
  output logic                overrun,
  output logic [LEN_W-1:0]    word_cnt
);

  state_t              state_q,   state_d;
  mode_t               mode_q,    mode_d;
  logic [PERIOD_W-1:0] period_q,  period_d;
  logic [LEN_W-1:0]    burst_q,   burst_d;
  logic [PERIOD_W-1:0] tick_q,    tick_d;
  logic                valid_q,   valid_d;
  logic [DATA_W-1:0]   data_q,    data_d;
  logic                done_q,    done_d;
  logic                overrun_q, overrun_d;
  logic [LEN_W-1:0]    cnt_q,     cnt_d;

  logic                pat_load;
  logic                pat_adv;
  mode_t               core_mode;
  logic [DATA_W-1:0]   pat_word;

  logic                accept;
  logic [LEN_W-1:0]    cnt_inc;
  logic                last_acc;
  logic                fire;

  assign accept   = valid_q && ready;
  assign cnt_inc  = cnt_q + 1'b1;
  assign last_acc = accept && (burst_q != '0) && (cnt_inc == burst_q);

  // The core loads with the live mode input at start, then steps with the latched mode.
  assign core_mode = (state_q == ST_IDLE) ? mode_t'(mode) : mode_q;

  pattern_core #(
    .DATA_W    (DATA_W),
    .LFSR_POLY (LFSR_POLY),
    .LFSR_SEED (LFSR_SEED)
  ) u_pattern (
    .clk       (clk),
    .n_rst     (n_rst),
    .load_i    (pat_load),
    .advance_i (pat_adv),
    .mode_i    (core_mode),
    .word_o    (pat_word)
  );

  // Next-state, rate timer, slot firing and handshake bookkeeping.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    period_d  = period_q;
    burst_d   = burst_q;
    tick_d    = tick_q;
    valid_d   = valid_q;
    data_d    = data_q;
    done_d    = 1'b0;
    overrun_d = overrun_q;
    cnt_d     = cnt_q;
    pat_load  = 1'b0;
    pat_adv   = 1'b0;
    fire      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d    = mode_t'(mode);
          period_d  = period;
          burst_d   = burst_len;
          pat_load  = 1'b1;
          tick_d    = '0;
          cnt_d     = '0;
          overrun_d = 1'b0;
          state_d   = ST_RUN;
        end
      end

      ST_RUN: begin
        if (accept) cnt_d = cnt_inc;
        // The final burst accept and stop both end slot firing; a word that is
        // still unaccepted after this cycle is finished off in DRAIN.
        if (stop || last_acc) begin
          if (accept || !valid_q) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DRAIN;
          end
        end else begin
          if (enable) begin
            if (tick_q == period_q) begin
              tick_d = '0;
              fire   = 1'b1;
            end else begin
              tick_d = tick_q + 1'b1;
            end
          end
          if (fire) begin
            if (!valid_q || accept) begin
              valid_d = 1'b1;
              data_d  = pat_word;
              pat_adv = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else if (accept) begin
            valid_d = 1'b0;
          end
        end
      end

      ST_DRAIN: begin
        if (accept) begin
          cnt_d   = cnt_inc;
          valid_d = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously by n_rst.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_CNT;
      period_q  <= '0;
      burst_q   <= '0;
      tick_q    <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      period_q  <= period_d;
      burst_q   <= burst_d;
      tick_q    <= tick_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      cnt_q     <= cnt_d;
    end
  end

  assign data     = data_q;
  assign valid    = valid_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign overrun  = overrun_q;
  assign word_cnt = cnt_q;

endmodule

// File: tb/tb_stream_pattern_gen.sv
// Scoreboard bench for stream_pattern_gen: expected words are queued at run
// start and popped by a monitor on every accepted handshake.
module tb_stream_pattern_gen;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned PERIOD_W = 8;
  localparam int unsigned LEN_W    = 16;

  logic                clk;
  logic                n_rst;
  logic                enable;
  logic                start;
  logic                stop;
  logic [1:0]          mode;
  logic [PERIOD_W-1:0] period;
  logic [LEN_W-1:0]    burst_len;
  logic [DATA_W-1:0]   data;
  logic                valid;
  logic                ready;
  logic                busy;
  logic                done;
  logic                overrun;
  logic [LEN_W-1:0]    word_cnt;

  stream_pattern_gen #(
    .DATA_W    (DATA_W),
    .PERIOD_W  (PERIOD_W),
    .LEN_W     (LEN_W),
    .LFSR_POLY (64'h8020_0003),
    .LFSR_SEED (64'h1)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .enable    (enable),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .period    (period),
    .burst_len (burst_len),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun),
    .word_cnt  (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int t0     = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic [DATA_W-1:0] sb_q[$];
  int                acc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [DATA_W-1:0] model_init(input int m);
    case (m)
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h0000_0001;
      default: return 32'h5555_5555;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] model_next(input int m, input logic [DATA_W-1:0] p);
    case (m)
      0: return p + 32'd1;
      1: return (p >> 1) ^ (p[0] ? 32'h8020_0003 : 32'h0);
      2: return {p[DATA_W-2:0], p[DATA_W-1]};
      default: return ~p;
    endcase
  endfunction

  // Queue the first n words of mode m in order.
  task automatic push_words(input int m, input int n);
    logic [DATA_W-1:0] p;
    p = model_init(m);
    for (int i = 0; i < n; i++) begin
      sb_q.push_back(p);
      p = model_next(m, p);
    end
  endtask

  // Monitor: compare each accepted word against the scoreboard.
  always @(negedge clk) begin
    if (n_rst && valid && ready) begin
      if (sb_q.size() > 0) check_eq("sb_data", 64'(data), 64'(sb_q.pop_front()));
      else                 check_eq("sb_underflow", 64'(sb_q.size()), 64'd1);
      acc_q.push_back(cyc);
    end
    if (n_rst && done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic run_start(input int m, input int per, input int bl);
    @(posedge clk); #1;
    mode = 2'(m); period = PERIOD_W'(per); burst_len = LEN_W'(bl); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy) check_eq({tag, "_idle_timeout"}, 64'(busy), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    int d0;
    int n;
    n_rst = 1'b0; enable = 1'b1; start = 1'b0; stop = 1'b0;
    mode = '0; period = '0; burst_len = '0; ready = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_valid", 64'(valid), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_overrun", 64'(overrun), 64'd0);
    check_eq("rst_word_cnt", 64'(word_cnt), 64'd0);
    check_eq("rst_data", 64'(data), 64'd0);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    // Counter, period 17, burst 4: slots 18 cycles apart, done one cycle after last accept.
    acc_q.delete(); d0 = done_cnt;
    push_words(0, 4);
    run_start(0, 17, 4);
    wait_idle("t1", 200);
    check_eq("t1_acc_count", 64'(acc_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < acc_q.size(); i++)
      check_eq("t1_acc_cycle", 64'(acc_q[i] - t0), 64'(18 * (i + 1)));
    check_eq("t1_done_cycle", 64'(done_cyc - t0), 64'd73);
    check_eq("t1_done_pulses", 64'(done_cnt - d0), 64'd1);
    check_eq("t1_word_cnt", 64'(word_cnt), 64'd4);
    check_eq("t1_overrun", 64'(overrun), 64'd0);

    // LFSR, period 0: one word per cycle back to back.
    acc_q.delete(); d0 = done_cnt;
    push_words(1, 3);
    run_start(1, 0, 3);
    wait_idle("t2", 50);
    check_eq("t2_acc_count", 64'(acc_q.size()), 64'd3);
    for (int i = 0; i < 3 && i < acc_q.size(); i++)
      check_eq("t2_acc_cycle", 64'(acc_q[i] - t0), 64'(i + 1));
    check_eq("t2_word_cnt", 64'(word_cnt), 64'd3);
    check_eq("t2_done_pulses", 64'(done_cnt - d0), 64'd1);

    // Walking-one with the sink stalled: word held, overrun set, no pattern skip.
    push_words(2, 3);
    ready = 1'b0;
    run_start(2, 0, 3);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check_eq("t3_stall_valid", 64'(valid), 64'd1);
      check_eq("t3_stall_data", 64'(data), 64'h1);
      @(negedge clk);
    end
    check_eq("t3_overrun", 64'(overrun), 64'd1);
    ready = 1'b1;
    wait_idle("t3", 50);
    check_eq("t3_word_cnt", 64'(word_cnt), 64'd3);
    check_eq("t3_overrun_sticky", 64'(overrun), 64'd1);

    // Continuous counter, stop while word 5 is pending: drained, then done.
    d0 = done_cnt;
    push_words(0, 6);
    run_start(0, 1, 0);
    n = 0;
    @(negedge clk);
    while (word_cnt != 16'd5 && n < 100) begin @(negedge clk); n++; end
    check_eq("t4_reach_5", 64'(word_cnt), 64'd5);
    ready = 1'b0;
    n = 0;
    @(negedge clk);
    while (!valid && n < 20) begin @(negedge clk); n++; end
    check_eq("t4_pending_valid", 64'(valid), 64'd1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check_eq("t4_drain_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 2; i++) begin
      check_eq("t4_drain_data", 64'(data), 64'd5);
      @(negedge clk);
    end
    ready = 1'b1;
    wait_idle("t4", 20);
    check_eq("t4_word_cnt", 64'(word_cnt), 64'd6);
    check_eq("t4_done_pulses", 64'(done_cnt - d0), 64'd1);

    // Period 3 with a 10-cycle enable pause; mid-run config changes and start are ignored.
    acc_q.delete();
    push_words(0, 4);
    run_start(0, 3, 4);
    mode = 2'd2; period = 8'd0; burst_len = 16'd1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(valid && ready) && n < 50) begin @(negedge clk); n++; end
    enable = 1'b0;
    repeat (10) @(negedge clk);
    enable = 1'b1;
    wait_idle("t5", 100);
    check_eq("t5_acc_count", 64'(acc_q.size()), 64'd4);
    if (acc_q.size() == 4) begin
      check_eq("t5_gap1", 64'(acc_q[1] - acc_q[0]), 64'd14);
      check_eq("t5_gap2", 64'(acc_q[2] - acc_q[1]), 64'd4);
      check_eq("t5_gap3", 64'(acc_q[3] - acc_q[2]), 64'd4);
    end
    check_eq("t5_overrun", 64'(overrun), 64'd0);
    check_eq("t5_word_cnt", 64'(word_cnt), 64'd4);

    // Reset mid-burst with a pending word, then a fresh checkerboard run.
    ready = 1'b0;
    run_start(3, 0, 8);
    repeat (3) @(negedge clk);
    check_eq("t6_pre_valid", 64'(valid), 64'd1);
    d0 = done_cnt;
    n_rst = 1'b0;
    #1;
    check_eq("t6_rst_valid", 64'(valid), 64'd0);
    check_eq("t6_rst_busy", 64'(busy), 64'd0);
    check_eq("t6_rst_word_cnt", 64'(word_cnt), 64'd0);
    check_eq("t6_rst_overrun", 64'(overrun), 64'd0);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("t6_no_done", 64'(done_cnt - d0), 64'd0);
    sb_q.delete();
    push_words(3, 2);
    ready = 1'b1;
    run_start(3, 0, 2);
    wait_idle("t6", 50);
    check_eq("t6_word_cnt", 64'(word_cnt), 64'd2);
    check_eq("t6_sb_drained", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
